// File: rtl/axis_detector_pkg.sv
// Shared types and constants for the detector run controller.
package axis_detector_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_TRAILER = 3'd3,
        ST_DONE    = 3'd4
    } run_state_e;

    localparam logic [15:0] TRAILER_TAG     = 16'hFFFF;
    localparam int          WORDS_PER_EVENT = 4;
    localparam int          EVENT_W         = 128;
    localparam int          WORD_W          = 32;

endpackage

// File: rtl/axis_detector_serializer.sv
// One-event holding slot in front of a 4-word shifter. Words leave LSB first,
// so {time, data} goes out as data[31:0], data[63:32], time[31:0], time[63:32].
module axis_detector_serializer
    import axis_detector_pkg::*;
(
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               load,
    input  logic [EVENT_W-1:0] load_data,
    output logic               load_ok,
    output logic               empty,
    output logic [WORD_W-1:0]  m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready
);

    logic               r_hold_vld;
    logic [EVENT_W-1:0] r_hold_data;
    logic               r_sh_vld;
    logic [EVENT_W-1:0] r_sh_data;
    logic [1:0]         r_word_cnt;

    logic w_xfer;
    logic w_last;
    logic w_sh_free;

    assign w_xfer    = r_sh_vld & m_axis_tready;
    assign w_last    = w_xfer & (r_word_cnt == 2'(WORDS_PER_EVENT - 1));
    // Shifter can take a new event this cycle (empty, or final word leaving).
    assign w_sh_free = ~r_sh_vld | w_last;
    // Room exists if the slot is empty or the slot drains into the shifter now.
    assign load_ok   = ~r_hold_vld | w_last;
    assign empty     = ~r_hold_vld & ~r_sh_vld;

    assign m_axis_tdata  = r_sh_data[WORD_W-1:0];
    assign m_axis_tvalid = r_sh_vld;

    // Shift on handshake; refill from the slot (or straight from input) with no bubble.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
            r_sh_vld    <= 1'b0;
            r_sh_data   <= '0;
            r_word_cnt  <= '0;
        end else if (!w_sh_free) begin
            if (w_xfer) begin
                r_sh_data  <= r_sh_data >> WORD_W;
                r_word_cnt <= r_word_cnt + 2'd1;
            end
            if (load) begin
                r_hold_vld  <= 1'b1;
                r_hold_data <= load_data;
            end
        end else begin
            r_word_cnt <= '0;
            if (r_hold_vld) begin
                r_sh_vld   <= 1'b1;
                r_sh_data  <= r_hold_data;
                r_hold_vld <= load;
                if (load) r_hold_data <= load_data;
            end else if (load) begin
                r_sh_vld  <= 1'b1;
                r_sh_data <= load_data;
            end else begin
                r_sh_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axis_detector_run_ctrl.sv
// Run controller: gates detector events into bounded runs, serialises them to
// 32-bit AXI-Stream and closes each run with a tlast trailer carrying the drop count.
module axis_detector_run_ctrl
    import axis_detector_pkg::*;
#(
    parameter int DROP_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [1:0]            ctrl,
    input  logic [31:0]           event_limit,
    input  logic [31:0]           time_limit,
    input  logic [127:0]          s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic [31:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [2:0]            sts_state,
    output logic [31:0]           sts_events,
    output logic [DROP_WIDTH-1:0] sts_drops,
    output logic [31:0]           sts_time
);

    run_state_e            r_state;
    run_state_e            w_state_nxt;
    logic                  r_start_prev;
    logic [31:0]           r_events;
    logic [DROP_WIDTH-1:0] r_drops;
    logic [31:0]           r_time;

    logic                  w_start_run;
    logic                  w_in_run;
    logic                  w_load;
    logic                  w_load_ok;
    logic                  w_drop;
    logic [31:0]           w_events_nxt;
    logic                  w_exit;
    logic [31:0]           w_ser_tdata;
    logic                  w_ser_tvalid;
    logic                  w_ser_empty;

    // Stop wins over a simultaneous start; only IDLE/DONE honour a start edge.
    assign w_start_run  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) &&
                          ctrl[0] && !r_start_prev && !ctrl[1];
    assign w_in_run     = (r_state == ST_RUN);
    assign w_load       = w_in_run & s_axis_tvalid & w_load_ok;
    assign w_drop       = w_in_run & s_axis_tvalid & ~w_load_ok;
    assign w_events_nxt = r_events + 32'(w_load);
    assign w_exit       = ctrl[1] ||
                          ((event_limit != '0) && (w_events_nxt == event_limit)) ||
                          ((time_limit  != '0) && ((r_time + 32'd1) == time_limit));

    axis_detector_serializer u_ser (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .load          (w_load),
        .load_data     (s_axis_tdata),
        .load_ok       (w_load_ok),
        .empty         (w_ser_empty),
        .m_axis_tdata  (w_ser_tdata),
        .m_axis_tvalid (w_ser_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    // State register.
    always_ff @(posedge aclk) begin
        if (!aresetn) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_start_run)   w_state_nxt = ST_RUN;
            ST_RUN:           if (w_exit)        w_state_nxt = ST_FLUSH;
            ST_FLUSH:         if (w_ser_empty)   w_state_nxt = ST_TRAILER;
            ST_TRAILER:       if (m_axis_tready) w_state_nxt = ST_DONE;
            default:                             w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered copy of start for edge detection.
    always_ff @(posedge aclk) begin
        if (!aresetn) r_start_prev <= 1'b0;
        else          r_start_prev <= ctrl[0];
    end

    // Run counters: cleared on run start, advanced only in RUN, held otherwise.
    always_ff @(posedge aclk) begin
        if (!aresetn || w_start_run) begin
            r_events <= '0;
            r_drops  <= '0;
            r_time   <= '0;
        end else if (w_in_run) begin
            r_events <= w_events_nxt;
            r_time   <= r_time + 32'd1;
            if (w_drop && (r_drops != {DROP_WIDTH{1'b1}}))
                r_drops <= r_drops + DROP_WIDTH'(1);
        end
    end

    assign m_axis_tdata  = (r_state == ST_TRAILER) ? {TRAILER_TAG, 16'(r_drops)} : w_ser_tdata;
    assign m_axis_tvalid = w_ser_tvalid | (r_state == ST_TRAILER);
    assign m_axis_tlast  = (r_state == ST_TRAILER);
    assign sts_state     = r_state;
    assign sts_events    = r_events;
    assign sts_drops     = r_drops;
    assign sts_time      = r_time;

endmodule

// File: tb/tb_axis_detector_run_ctrl.sv
// Bench for axis_detector_run_ctrl: randomized events/backpressure against a
// word-count reference model of the run controller.
module tb_axis_detector_run_ctrl;

    localparam int DW = 3;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [1:0]    ctrl = '0;
    logic [31:0]   event_limit = '0;
    logic [31:0]   time_limit = '0;
    logic [127:0]  s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic [31:0]   m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready = 1'b0;
    logic [2:0]    sts_state;
    logic [31:0]   sts_events;
    logic [DW-1:0] sts_drops;
    logic [31:0]   sts_time;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    // Reference model: run state, counters and words still owed downstream.
    int          m_st;
    bit          m_prev;
    int          m_w;
    int unsigned m_ev, m_dr, m_tm;

    always #5 aclk = ~aclk;

    axis_detector_run_ctrl #(.DROP_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn), .ctrl(ctrl),
        .event_limit(event_limit), .time_limit(time_limit),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tready(m_tready),
        .sts_state(sts_state), .sts_events(sts_events),
        .sts_drops(sts_drops), .sts_time(sts_time)
    );

    // Capture every output handshake; inputs only change just after posedge.
    always @(negedge aclk)
        if (aresetn && m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Model: at most two events (8 words) in flight; an event fits if the words
    // still owed after this cycle's handshake leave room for 4 more.
    task automatic model_cycle();
        int h;
        bit edge_;
        if (!aresetn) begin
            repeat (m_w) void'(exp_q.pop_back());
            if (m_st == 3) void'(exp_q.pop_back());
            m_st = 0; m_prev = 0; m_w = 0; m_ev = 0; m_dr = 0; m_tm = 0;
            return;
        end
        edge_  = ctrl[0] && !m_prev;
        m_prev = ctrl[0];
        case (m_st)
            0, 4: if (edge_ && !ctrl[1]) begin
                m_st = 1; m_ev = 0; m_dr = 0; m_tm = 0;
            end
            1: begin
                h = (m_w > 0 && m_tready) ? 1 : 0;
                if (s_tvalid) begin
                    if (m_w - h <= 4) begin
                        m_ev++;
                        for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, s_tdata[32*k +: 32]});
                        m_w += 4;
                    end else if (m_dr < (1 << DW) - 1) begin
                        m_dr++;
                    end
                end
                m_w -= h;
                m_tm++;
                if (ctrl[1] || (event_limit != 0 && m_ev == event_limit) ||
                    (time_limit != 0 && m_tm == time_limit))
                    m_st = 2;
            end
            2: begin
                if (m_w == 0) begin
                    m_st = 3;
                    exp_q.push_back({1'b1, 16'hFFFF, 16'(m_dr)});
                end else if (m_tready) begin
                    m_w--;
                end
            end
            3: if (m_tready) m_st = 4;
            default: m_st = 0;
        endcase
    endtask

    task automatic tick();
        model_cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0; ctrl = '0; s_tvalid = 1'b0; m_tready = 1'b0;
        repeat (2) tick();
        aresetn = 1'b1;
        got_q.delete(); exp_q.delete();
    endtask

    task automatic start_run();
        ctrl[0] = 1'b1; tick(); ctrl[0] = 1'b0;
    endtask

    // Drive events with gaps in [gmin,gmax], random tready, optional stop, until the model is DONE.
    task automatic run_stim(input int n_ev, input int gmin, input int gmax, input int pct,
                            input int stop_at, input int max_cyc, output bit timed_out);
        int cyc = 0, gap = 0, sent = 0;
        timed_out = 0;
        while (m_st != 4) begin
            if (cyc >= max_cyc) begin timed_out = 1; break; end
            if (sent < n_ev && gap == 0) begin
                s_tvalid = 1'b1; s_tdata = rnd128(); sent++;
                gap = int'($urandom_range(gmax, gmin)) - 1;
            end else begin
                s_tvalid = 1'b0;
                if (gap > 0) gap--;
            end
            m_tready = ($urandom_range(99) < pct);
            ctrl[1]  = (stop_at >= 0 && cyc >= stop_at);
            tick(); cyc++;
        end
        s_tvalid = 1'b0; ctrl = '0; m_tready = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (sts_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", sts_state); end
        n_tests++; if ({m_tvalid, m_tlast, m_tdata} !== 34'd0) begin n_fail++; $display("FAIL reset_axis: got v=%b l=%b d=%h want all 0", m_tvalid, m_tlast, m_tdata); end
        n_tests++; if ({sts_events, sts_drops, sts_time} !== '0) begin n_fail++; $display("FAIL reset_sts: got ev=%0d dr=%0d tm=%0d want 0", sts_events, sts_drops, sts_time); end
    endtask

    task automatic test_event_limit();
        bit to, bad;
        do_reset();
        event_limit = 32'd3; time_limit = 32'd0;
        start_run();
        run_stim(5, 5, 5, 100, -1, 500, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL evlim_timeout: got timeout want DONE"); end
        bad = (got_q.size() != exp_q.size());
        for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1;
        n_tests++; if (bad) begin n_fail++; $display("FAIL evlim_stream: got %0d words want %0d matching words", got_q.size(), exp_q.size()); end
        n_tests++; if (got_q.size() != 13) begin n_fail++; $display("FAIL evlim_count: got %0d words want 13", got_q.size()); end
        else if (got_q[12] !== {1'b1, 32'hFFFF0000}) begin n_fail++; $display("FAIL evlim_trailer: got %h want 1ffff0000", got_q[12]); end
        n_tests++; if (sts_events !== 32'd3 || sts_state !== 3'd4) begin n_fail++; $display("FAIL evlim_sts: got ev=%0d st=%0d want 3/4", sts_events, sts_state); end
    endtask

    task automatic test_time_limit();
        bit to;
        do_reset();
        event_limit = 32'd0; time_limit = 32'd100;
        start_run();
        run_stim(0, 5, 5, 100, -1, 500, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL tlim_timeout: got timeout want DONE"); end
        n_tests++; if (got_q.size() != 1 || got_q[0] !== {1'b1, 32'hFFFF0000}) begin n_fail++; $display("FAIL tlim_stream: got %0d words first=%h want 1 word 1ffff0000", got_q.size(), got_q.size() ? got_q[0] : 33'h0); end
        n_tests++; if (sts_time !== 32'd100 || sts_events !== 32'd0) begin n_fail++; $display("FAIL tlim_sts: got tm=%0d ev=%0d want 100/0", sts_time, sts_events); end
    endtask

    task automatic test_backpressure();
        bit bad;
        int cyc = 0;
        do_reset();
        event_limit = 32'd0; time_limit = 32'd0;
        start_run();
        for (int c = 0; c < 40; c++) begin
            m_tready = 1'b0;
            s_tvalid = (c % 5 == 0 && c < 20);
            s_tdata  = rnd128();
            tick();
        end
        s_tvalid = 1'b0; m_tready = 1'b1; ctrl[1] = 1'b1;
        while (m_st != 4 && cyc < 200) begin tick(); cyc++; end
        ctrl = '0; repeat (2) tick();
        n_tests++; if (sts_drops !== 3'd2) begin n_fail++; $display("FAIL bp_drops: got %0d want 2", sts_drops); end
        bad = (got_q.size() != exp_q.size());
        for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1;
        n_tests++; if (bad || got_q.size() != 9) begin n_fail++; $display("FAIL bp_stream: got %0d words want 9 matching words", got_q.size()); end
        else if (got_q[8] !== {1'b1, 32'hFFFF0002}) begin n_fail++; $display("FAIL bp_trailer: got %h want 1ffff0002", got_q[8]); end
    endtask

    task automatic test_stop_flush();
        bit bad;
        int c = 0;
        do_reset();
        event_limit = 32'd0; time_limit = 32'd0;
        start_run();
        while (m_st != 4 && c < 200) begin
            s_tvalid = (c == 0 || c == 1 || c == 6 || c == 9);
            s_tdata  = rnd128();
            m_tready = !(c >= 3 && c <= 7);
            ctrl[1]  = (c >= 3);
            tick(); c++;
        end
        s_tvalid = 1'b0; ctrl = '0; repeat (2) tick();
        bad = (got_q.size() != exp_q.size());
        for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1;
        n_tests++; if (bad || got_q.size() != 9) begin n_fail++; $display("FAIL stop_stream: got %0d words want 9 matching words", got_q.size()); end
        n_tests++; if (sts_drops !== 3'd0 || sts_events !== 32'd2) begin n_fail++; $display("FAIL stop_sts: got dr=%0d ev=%0d want 0/2", sts_drops, sts_events); end
    endtask

    task automatic test_start_stop();
        bit to;
        do_reset();
        event_limit = 32'd0; time_limit = 32'd30;
        ctrl = 2'b11; tick(); ctrl = '0;
        repeat (10) tick();
        n_tests++; if (sts_state !== 3'd0 || got_q.size() != 0) begin n_fail++; $display("FAIL startstop_idle: got st=%0d words=%0d want 0/0", sts_state, got_q.size()); end
        start_run();
        repeat (10) tick();
        ctrl[0] = 1'b1; tick(); ctrl[0] = 1'b0; tick();
        n_tests++; if (sts_state !== 3'd1 || sts_time !== 32'd12) begin n_fail++; $display("FAIL restart_ignored: got st=%0d tm=%0d want 1/12", sts_state, sts_time); end
        run_stim(0, 5, 5, 100, -1, 200, to);
        n_tests++; if (to || sts_time !== 32'd30 || sts_state !== 3'd4 || got_q.size() != 1) begin n_fail++; $display("FAIL restart_final: got tm=%0d st=%0d words=%0d want 30/4/1", sts_time, sts_state, got_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit bad;
        do_reset();
        event_limit = 32'd0; time_limit = 32'd0;
        start_run();
        m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = rnd128(); tick();
        s_tvalid = 1'b0; tick(); tick();
        aresetn = 1'b0; tick();
        n_tests++; if ({m_tvalid, m_tlast, m_tdata} !== 34'd0 || sts_state !== 3'd0) begin n_fail++; $display("FAIL rstmid_out: got v=%b l=%b d=%h st=%0d want all 0", m_tvalid, m_tlast, m_tdata, sts_state); end
        aresetn = 1'b1; repeat (4) tick();
        bad = (got_q.size() != exp_q.size());
        for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1;
        n_tests++; if (bad || got_q.size() != 2) begin n_fail++; $display("FAIL rstmid_stream: got %0d words want 2 matching words, no trailer", got_q.size()); end
    endtask

    // Back-to-back runs from DONE with random limits, gaps, backpressure and stops.
    task automatic test_random();
        bit to, bad;
        do_reset();
        for (int it = 0; it < 8; it++) begin
            got_q.delete(); exp_q.delete();
            event_limit = $urandom_range(6, 0);
            time_limit  = $urandom_range(150, 20);
            start_run();
            run_stim(20, 1, 8, int'($urandom_range(100, 20)),
                     ($urandom_range(1) != 0) ? int'($urandom_range(120, 5)) : -1, 2000, to);
            bad = to || (got_q.size() != exp_q.size());
            for (int i = 0; i < got_q.size() && !bad; i++) if (got_q[i] !== exp_q[i]) bad = 1;
            n_tests++; if (bad) begin n_fail++; $display("FAIL rand_stream[%0d]: got %0d words want %0d matching words (timeout=%0b)", it, got_q.size(), exp_q.size(), to); end
            n_tests++; if (sts_events !== m_ev || sts_drops !== DW'(m_dr) || sts_time !== m_tm || sts_state !== 3'd4) begin
                n_fail++; $display("FAIL rand_sts[%0d]: got ev=%0d dr=%0d tm=%0d st=%0d want %0d/%0d/%0d/4", it, sts_events, sts_drops, sts_time, sts_state, m_ev, m_dr, m_tm);
            end
        end
    endtask

    initial begin
        m_st = 0; m_prev = 0; m_w = 0; m_ev = 0; m_dr = 0; m_tm = 0;
        test_reset();
        test_event_limit();
        test_time_limit();
        test_backpressure();
        test_stop_flush();
        test_start_stop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
